// File: rtl/rv_pkg.sv
// rv_pkg: constants and types shared by the RV32I decode path.
//   XLEN     - datapath width
//   OPC_*    - major opcodes recognised by decode
//   F3_*     - ALU funct3 encodings
//   imm_t    - sign-extended immediate type
//   f3_is_shift / f3_is_slt - funct3 class helpers used for operand steering
package rv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef logic [XLEN-1:0] imm_t;

  function automatic logic f3_is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction

  function automatic logic f3_is_slt(input logic [2:0] f3);
    return (f3 == F3_SLT) || (f3 == F3_SLTU);
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate extraction and sign extension.
//   i_instr - 32-bit instruction word
//   o_imm   - I/S/B/U immediate chosen by opcode, sign-extended; 0 for
//             formats without an immediate (R-type) and unknown opcodes
module imm_gen
  import rv_pkg::*;
(
  input  logic [31:0] i_instr,
  output imm_t        o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_instr[6:0])
      OPC_OPIMM:
        o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                 i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        o_imm = {i_instr[31:12], 12'b0};
      default:
        o_imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register-file read and busy scoreboard.
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - instruction handshake from fetch
//   in_instr, in_pc          - instruction word and address
//   rs1_addr/rs2_addr        - combinational register file read addresses
//   rs1_data/rs2_data        - register file read data (same cycle)
//   wb_valid, wb_rd          - writeback retirement, clears busy bit
//   flush                    - squash held bundle
//   out_valid/out_ready      - bundle handshake to execute
//   op_select, alt_operator, branch_mode, op1, op2 - ALU controls/operands
//   out_imm, out_pc, out_rd, out_wb_en, illegal    - bundle metadata
module decode_stage
  import rv_pkg::*;
#(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      op_select,
  output logic            alt_operator,
  output logic            branch_mode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_wb_en,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [2:0]      w_f3;
  logic [4:0]      w_rd;
  imm_t            w_imm;
  logic            w_use1, w_use2, w_writes, w_illegal, w_wb_en;
  logic [2:0]      w_sel;
  logic            w_alt, w_bm;
  logic [XLEN-1:0] w_op1, w_op2;
  logic            w_hazard, w_accept, w_flush_clr;
  logic [NREG-1:0] w_busy_next;

  logic [NREG-1:0] r_busy;
  logic            r_valid, r_alt, r_bm, r_wb_en, r_illegal;
  logic [2:0]      r_sel;
  logic [XLEN-1:0] r_op1, r_op2, r_imm, r_pc;
  logic [4:0]      r_rd;

  assign w_opcode = in_instr[6:0];
  assign w_f3     = in_instr[14:12];
  assign w_rd     = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  imm_gen u_imm_gen (
    .i_instr (in_instr),
    .o_imm   (w_imm)
  );

  // The ALU takes shift amounts on op1 and evaluates SLT as "op1 > op2",
  // hence the swapped operand order for those classes.
  always_comb begin
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_writes  = 1'b0;
    w_illegal = 1'b0;
    w_sel     = F3_ADD;
    w_alt     = 1'b0;
    w_bm      = 1'b0;
    w_op1     = '0;
    w_op2     = '0;
    case (w_opcode)
      OPC_OP: begin
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_writes = 1'b1;
        w_sel    = w_f3;
        w_alt    = ((w_f3 == F3_ADD) || (w_f3 == F3_SR)) ? in_instr[30] : 1'b0;
        if (f3_is_shift(w_f3)) begin
          w_op1 = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
          w_op2 = rs1_data;
        end else if (f3_is_slt(w_f3)) begin
          w_op1 = rs2_data;
          w_op2 = rs1_data;
        end else begin
          w_op1 = rs1_data;
          w_op2 = rs2_data;
        end
      end
      OPC_OPIMM: begin
        w_use1   = 1'b1;
        w_writes = 1'b1;
        w_sel    = w_f3;
        w_alt    = (w_f3 == F3_SR) ? in_instr[30] : 1'b0;
        if (f3_is_shift(w_f3)) begin
          w_op1 = {{(XLEN-5){1'b0}}, w_imm[4:0]};
          w_op2 = rs1_data;
        end else if (f3_is_slt(w_f3)) begin
          w_op1 = w_imm;
          w_op2 = rs1_data;
        end else begin
          w_op1 = rs1_data;
          w_op2 = w_imm;
        end
      end
      OPC_BRANCH: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_sel  = w_f3;
        w_bm   = 1'b1;
        w_op1  = rs1_data;
        w_op2  = rs2_data;
      end
      OPC_LUI: begin
        w_writes = 1'b1;
        w_op1    = w_imm;
      end
      OPC_AUIPC: begin
        w_writes = 1'b1;
        w_op1    = in_pc;
        w_op2    = w_imm;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_wb_en = w_writes && (w_rd != 5'd0);

  // Scoreboard is read from registered bits only, so a source retiring this
  // cycle still stalls once.
  assign w_hazard = (w_use1  && r_busy[rs1_addr]) ||
                    (w_use2  && r_busy[rs2_addr]) ||
                    (w_wb_en && r_busy[w_rd]);

  assign in_ready    = (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_accept    = in_valid && in_ready;
  assign w_flush_clr = flush && r_valid && r_wb_en;

  // Per-register next state: a new owner being set outranks any clear.
  assign w_busy_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      assign w_busy_next[gi] =
          (w_accept && w_wb_en && (w_rd == 5'(gi))) ||
          (r_busy[gi] && !(wb_valid && (wb_rd == 5'(gi)))
                      && !(w_flush_clr && (r_rd == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_valid   <= 1'b0;
      r_sel     <= '0;
      r_alt     <= 1'b0;
      r_bm      <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_imm     <= '0;
      r_pc      <= '0;
      r_rd      <= '0;
      r_wb_en   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid   <= 1'b1;
        r_sel     <= w_sel;
        r_alt     <= w_alt;
        r_bm      <= w_bm;
        r_op1     <= w_op1;
        r_op2     <= w_op2;
        r_imm     <= w_imm;
        r_pc      <= in_pc;
        r_rd      <= w_rd;
        r_wb_en   <= w_wb_en;
        r_illegal <= w_illegal;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_valid;
  assign op_select    = r_sel;
  assign alt_operator = r_alt;
  assign branch_mode  = r_bm;
  assign op1          = r_op1;
  assign op2          = r_op2;
  assign out_imm      = r_imm;
  assign out_pc       = r_pc;
  assign out_rd       = r_rd;
  assign out_wb_en    = r_wb_en;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  op_select;
  logic        alt_operator, branch_mode;
  logic [31:0] op1, op2, out_imm, out_pc;
  logic [4:0]  out_rd;
  logic        out_wb_en, illegal;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_select(op_select), .alt_operator(alt_operator), .branch_mode(branch_mode),
    .op1(op1), .op2(op2), .out_imm(out_imm), .out_pc(out_pc),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic        alt;
    logic        bm;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        wb_en;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    exp_t        e;
  } vec_t;

  localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t w_act;

  assign w_act = {op_select, alt_operator, branch_mode, op1, op2, out_imm,
                  out_pc, out_rd, out_wb_en, illegal};

  task automatic check(input string nm, input logic [159:0] got, input logic [159:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] sel, input logic alt, input logic bm,
                              input logic [31:0] o1, input logic [31:0] o2,
                              input logic [31:0] imm, input logic [4:0] rd,
                              input logic wb, input logic ill);
    exp_t e;
    e.sel = sel; e.alt = alt; e.bm = bm; e.op1 = o1; e.op2 = o2; e.imm = imm;
    e.pc = '0; e.rd = rd; e.wb_en = wb; e.ill = ill;
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {f7, s2, s1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, s1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] s2,
      input logic [4:0] s1, input logic [2:0] f3);
    return {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  // Scoreboard consumer: a bundle transfers when valid && ready && !flush.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_bundle: got %h want none", w_act);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("bundle_pc_%h", e.pc), w_act, e);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input exp_t e);
    in_instr = instr; in_pc = pc; rs1_data = r1; rs2_data = r2; in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (in_ready) begin
        q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    n_checks++;
    n_fail++;
    $display("FAIL issue_timeout: got in_ready=0 for 20 cycles want 1 (pc %h)", pc);
    in_valid = 1'b0;
  endtask

  task automatic retire(input logic [4:0] rd);
    wb_valid = 1'b1; wb_rd = rd;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  vec_t v[12];

  initial begin
    exp_t        e;
    logic [31:0] busy_before;

    v[0]  = '{enc_r(7'h00, 2, 1, 3'b000, 3, OP), 32'h1000, 32'd5, 32'd7,
              mk(3'b000, 0, 0, 32'd5, 32'd7, 32'd0, 3, 1, 0)};
    v[1]  = '{enc_r(7'h20, 2, 1, 3'b000, 4, OP), 32'h1004, 32'd10, 32'd3,
              mk(3'b000, 1, 0, 32'd10, 32'd3, 32'd0, 4, 1, 0)};
    v[2]  = '{enc_i(12'h403, 1, 3'b101, 4, OPI), 32'h1008, 32'h80000000, 32'd0,
              mk(3'b101, 1, 0, 32'd3, 32'h80000000, 32'h403, 4, 1, 0)};
    v[3]  = '{enc_r(7'h00, 2, 1, 3'b001, 5, OP), 32'h100c, 32'd1, 32'hFFFFFF24,
              mk(3'b001, 0, 0, 32'd4, 32'd1, 32'd0, 5, 1, 0)};
    v[4]  = '{enc_r(7'h00, 2, 1, 3'b010, 6, OP), 32'h1010, 32'd3, 32'd9,
              mk(3'b010, 0, 0, 32'd9, 32'd3, 32'd0, 6, 1, 0)};
    v[5]  = '{enc_i(12'hFFF, 1, 3'b011, 7, OPI), 32'h1014, 32'd5, 32'd0,
              mk(3'b011, 0, 0, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 7, 1, 0)};
    v[6]  = '{enc_i(12'hFF0, 1, 3'b000, 8, OPI), 32'h1018, 32'd100, 32'd0,
              mk(3'b000, 0, 0, 32'd100, 32'hFFFFFFF0, 32'hFFFFFFF0, 8, 1, 0)};
    v[7]  = '{enc_b(13'h1FF8, 2, 1, 3'b000), 32'h101c, 32'd11, 32'd22,
              mk(3'b000, 0, 1, 32'd11, 32'd22, 32'hFFFFFFF8, 25, 0, 0)};
    v[8]  = '{enc_b(13'h0010, 2, 1, 3'b110), 32'h1020, 32'd1, 32'd2,
              mk(3'b110, 0, 1, 32'd1, 32'd2, 32'h10, 16, 0, 0)};
    v[9]  = '{enc_u(20'hABCDE, 9, 7'b0110111), 32'h1024, 32'd0, 32'd0,
              mk(3'b000, 0, 0, 32'hABCDE000, 32'd0, 32'hABCDE000, 9, 1, 0)};
    v[10] = '{enc_u(20'h00001, 10, 7'b0010111), 32'h100, 32'd0, 32'd0,
              mk(3'b000, 0, 0, 32'h100, 32'h1000, 32'h1000, 10, 1, 0)};
    v[11] = '{enc_r(7'h20, 2, 1, 3'b101, 0, OP), 32'h1028, 32'hF0, 32'h22,
              mk(3'b101, 1, 0, 32'd2, 32'hF0, 32'd0, 0, 0, 0)};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_bundle", w_act, '0);
    check("reset_valid_ready", {out_valid, in_ready}, {1'b0, 1'b1});
    check("reset_busy", dut.r_busy, '0);
    @(negedge clk);

    // Table-driven single instructions
    for (int i = 0; i < 12; i++) begin
      e = v[i].e;
      e.pc = v[i].pc;
      issue(v[i].instr, v[i].pc, v[i].r1, v[i].r2, e);
      retire(v[i].e.rd);
    end
    @(negedge clk);
    check("table_drained", q.size(), 0);

    // RAW stall: ADDI x5,x0,1 then ADD x6,x5,x5
    issue(enc_i(12'd1, 0, 3'b000, 5, OPI), 32'h2000, 32'd0, 32'd0,
          '{3'b000, 1'b0, 1'b0, 32'd0, 32'd1, 32'd1, 32'h2000, 5'd5, 1'b1, 1'b0});
    in_instr = enc_r(7'h00, 5, 5, 3'b000, 6, OP); in_pc = 32'h2004;
    rs1_data = 32'd1; rs2_data = 32'd1; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("raw_stall", in_ready, 1'b0);
      @(negedge clk);
    end
    wb_valid = 1'b1; wb_rd = 5'd5;
    #1;
    check("raw_no_bypass", in_ready, 1'b0);
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    check("raw_release", in_ready, 1'b1);
    q.push_back('{3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 32'h2004, 5'd6, 1'b1, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    retire(6);

    // Backpressure: hold for 3 cycles with a second instruction waiting
    out_ready = 1'b0;
    issue(enc_r(7'h00, 2, 1, 3'b000, 12, OP), 32'h3000, 32'd1, 32'd2,
          '{3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h3000, 5'd12, 1'b1, 1'b0});
    in_instr = enc_r(7'h00, 2, 1, 3'b000, 13, OP); in_pc = 32'h3004;
    rs1_data = 32'd3; rs2_data = 32'd4; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_hold", {out_valid, out_rd, op1, op2}, {1'b1, 5'd12, 32'd1, 32'd2});
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", in_ready, 1'b1);
    q.push_back('{3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 32'h3004, 5'd13, 1'b1, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    retire(12);
    retire(13);

    // Flush of a held bundle writing x7, flush coinciding with out_ready
    out_ready = 1'b0;
    issue(enc_i(12'd5, 0, 3'b000, 7, OPI), 32'h4000, 32'd0, 32'd0,
          '{3'b000, 1'b0, 1'b0, 32'd0, 32'd5, 32'd5, 32'h4000, 5'd7, 1'b1, 1'b0});
    q.delete(q.size() - 1);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    check("flush_in_ready", in_ready, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_drop", out_valid, 1'b0);
    check("flush_busy7", dut.r_busy[7], 1'b0);
    in_instr = enc_r(7'h00, 7, 7, 3'b000, 8, OP);
    #1;
    check("flush_no_stall", in_ready, 1'b1);
    @(negedge clk);
    issue(enc_r(7'h00, 7, 7, 3'b000, 8, OP), 32'h4004, 32'd5, 32'd5,
          '{3'b000, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 32'h4004, 5'd8, 1'b1, 1'b0});
    retire(8);

    // Unsupported opcode (load): passes downstream flagged, busy untouched
    busy_before = dut.r_busy;
    issue(enc_i(12'd4, 1, 3'b010, 11, 7'b0000011), 32'h5000, 32'd9, 32'd9,
          '{3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'h5000, 5'd11, 1'b0, 1'b1});
    check("load_busy", dut.r_busy, busy_before);
    @(negedge clk);

    // Reset while stalled, with flush also asserted
    out_ready = 1'b0;
    issue(enc_r(7'h00, 2, 1, 3'b000, 14, OP), 32'h6000, 32'd1, 32'd2,
          '{3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 32'h6000, 5'd14, 1'b1, 1'b0});
    in_instr = enc_r(7'h00, 2, 1, 3'b000, 15, OP); in_valid = 1'b1;
    rst = 1'b1; flush = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_mid_valid", out_valid, 1'b0);
    check("rst_mid_busy", dut.r_busy, '0);
    check("rst_mid_bundle", w_act, '0);
    @(negedge clk);
    check("queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the no-memory RV32I core. Accepts one instruction per cycle from fetch over a valid/ready handshake and reads the register file combinationally. It produces a registered bundle of ALU controls and operands (`op_select`, `alt_operator`, `branch_mode`, `op1`, `op2`) for the execute stage, plus writeback metadata. A per-register busy scoreboard stalls RAW/WAW hazards until writeback retires the producer.

## Interface
- `XLEN`, 32: datapath width.
- `NREG`, 32: architectural registers; x0 is hardwired zero.
- `clk` in 1: the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: decode accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: instruction address.
- `rs1_addr`, `rs2_addr` out 5: register file read addresses, driven combinationally from `in_instr[19:15]` and `in_instr[24:20]`.
- `rs1_data`, `rs2_data` in XLEN: register file read data, same cycle.
- `wb_valid` in 1: writeback retires a result this cycle.
- `wb_rd` in 5: register being retired.
- `flush` in 1: squash the held instruction (taken branch).
- `out_valid` out 1: bundle valid.
- `out_ready` in 1: execute accepts the bundle.
- `op_select` out 3: ALU operation.
- `alt_operator` out 1: SUB/SRA select.
- `branch_mode` out 1: ALU compare mode.
- `op1`, `op2` out XLEN: ALU operands.
- `out_imm` out XLEN: sign-extended immediate, used as the branch offset.
- `out_pc` out XLEN: instruction address.
- `out_rd` out 5: destination register.
- `out_wb_en` out 1: result is written back.
- `illegal` out 1: unsupported opcode.

## Operation
- Supported opcodes:
  - OP (0110011) and OP-IMM (0010011): `op_select` = funct3, `branch_mode` = 0.
  - BRANCH (1100011): `op_select` = funct3, `branch_mode` = 1, `out_wb_en` = 0.
  - LUI: op1 = U-imm, op2 = 0, `op_select` = 000.
  - AUIPC: op1 = pc, op2 = U-imm, `op_select` = 000.
- `alt_operator`:
  - OP: set to funct7[5] for funct3 000 and 101.
  - OP-IMM: set to instr[30] for funct3 101 only.
  - All other cases: 0.
- Operand mapping (the ALU takes the shift amount on op1 and computes "greater-than" for SLT):
  - Shifts: op1 = shamt (rs2 or imm[4:0], zero-extended), op2 = rs1.
  - SLT/SLTU/SLTI/SLTIU: op1 = rs2 or imm, op2 = rs1.
  - All other ALU ops: op1 = rs1, op2 = rs2 or imm.
  - Branches: op1 = rs1, op2 = rs2.
- Immediates are sign-extended to XLEN. SLTIU compares the sign-extended immediate as unsigned.
- Any other opcode: `illegal` = 1, `out_wb_en` = 0, and the bundle still passes downstream so execute can trap.
- `out_wb_en` = 1 iff the instruction writes a register and rd != 0.
- Scoreboard:
  - `busy[NREG-1:1]`; x0 is never busy.
  - A hazard exists if a used source is busy, or if `out_wb_en` would be 1 and rd is busy (WAW). Each busy bit therefore has exactly one owner.
  - Set the rd bit on accept when `out_wb_en` = 1. Clear the `wb_rd` bit on `wb_valid`.
  - Same-cycle set and clear of the same register: set wins.
  - No bypass: the scoreboard is read from registered bits, so a source retiring this cycle still stalls for one cycle.
- `in_ready` = (!`out_valid` || `out_ready`) && !hazard && !`flush`.
- Flush:
  - Drops the held bundle (`out_valid` → 0 next cycle).
  - Clears the busy bit the held bundle set, if any.
  - Accepts nothing that cycle.

## Timing
- Latency is one cycle: a bundle accepted at edge N is visible after N with `out_valid` = 1.
- Throughput is one instruction per cycle when there is no hazard and no backpressure.
- The output register holds stable while `out_valid` && !`out_ready`.
- `out_valid` stays 1 and the bundle stays unchanged until the handshake completes; there is no bubble on back-to-back transfers.
- Reset:
  - `out_valid`, `illegal`, `out_wb_en`, `alt_operator`, `branch_mode` = 0.
  - `op_select`, `op1`, `op2`, `out_imm`, `out_pc`, `out_rd` = 0.
  - `busy` = 0.
- `rst` mid-stall discards everything; `rst` has priority over `flush`.
- `flush` and `out_ready` in the same cycle: flush wins and the bundle is not counted as transferred.
- `in_ready` is combinational from `in_instr` (hazard), `out_ready` and `flush`; `in_ready` has no dependence on `in_valid`.

## Structure
- Shared package `rv_pkg` holds:
  - Opcode constants: `OPC_OP`, `OPC_OPIMM`, `OPC_BRANCH`, `OPC_LUI`, `OPC_AUIPC`.
  - ALU funct3 encodings.
  - An `XLEN` constant.
  - The `imm_t` type.
- Sub-module `imm_gen`: combinational I/S/B/U immediate extraction and sign extension, selected by opcode.
- The scoreboard lives in this module as a flat register vector.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7 → one cycle later `op_select`=000, alt=0, op1=5, op2=7, `out_rd`=3, `out_wb_en`=1.
- SRAI x4,x1,3 with rs1=0x80000000 → `op_select`=101, alt=1, op1=3, op2=0x80000000.
- ADDI x5,x0,1 then ADD x6,x5,x5 back-to-back → second instruction stalls (`in_ready`=0) until `wb_valid`/`wb_rd`=5, then issues one cycle after the busy bit clears.
- Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → bundle unchanged, `in_ready`=0 throughout, no instruction lost or duplicated.
- Assert `flush` while a bundle writing x7 is held → `out_valid`=0 next cycle, `busy[7]`=0, and a following read of x7 does not stall.
- Opcode 0000011 (load) → `illegal`=1, `out_wb_en`=0, `busy` unchanged.
